l2_request_arbiter: RTL and testbench

- Shares the L2 tag-stage entry slot between `NUM_REQUESTERS` core request ports and the bus interface's restart path.
- Each core port has a one-entry holding buffer; restarted (filled) requests take priority.
- A starvation counter bounds how long cores can be locked out by restarts.
- Output is one registered request per cycle into the L2 tag stage, frozen by the downstream stall.

---
 rtl/l2_request_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_l2_request_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter
//
// Shares the single L2 tag-stage entry slot between NUM_REQUESTERS core
// request ports and the bus interface's restart path. Each core port owns a
// one-entry holding buffer; restarted (filled) requests normally win, and a
// starvation counter bounds how many consecutive restart wins are allowed
// while any core buffer is waiting. One registered request per cycle is
// presented to the tag stage, and the whole selection path freezes on stall.
//
// Optional feature macro: L2_ARB_PERF_EN enables the two perf-event pulses on
// arb_perf_events; without it the port is tied to zero.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-low reset (0 = in reset)
//   req_valid        per-core request valid
//   req_packet       per-core request, core i in bits [i*PKT_W +: PKT_W]
//   req_ready        per-core holding buffer empty
//   restart_valid    restarted request pending
//   restart_packet   restarted request
//   restart_ack      restart taken this cycle (combinational)
//   stall            downstream pipeline stall
//   grant_valid      registered output request valid
//   grant_packet     registered output request
//   grant_is_restart output came from the restart path
//   grant_id         source core index (0 for restarts)
//   arb_perf_events  {core_starved, restart_preempt} single-cycle pulses
//
// Handshakes: a core transfer happens on a rising edge where req_valid[i] and
// req_ready[i] are both 1; req_ready depends only on buffer state, never on
// req_valid or stall. The restart source keeps restart_valid/restart_packet
// stable until a cycle in which restart_ack is 1; the transfer happens on
// that cycle's rising edge.

module l2_request_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int STARVE_LIMIT   = 8,
  parameter int PKT_W          = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQUESTERS-1:0]           req_valid,
  input  logic [NUM_REQUESTERS*PKT_W-1:0]     req_packet,
  output logic [NUM_REQUESTERS-1:0]           req_ready,
  input  logic                                restart_valid,
  input  logic [PKT_W-1:0]                    restart_packet,
  output logic                                restart_ack,
  input  logic                                stall,
  output logic                                grant_valid,
  output logic [PKT_W-1:0]                    grant_packet,
  output logic                                grant_is_restart,
  output logic [$clog2(NUM_REQUESTERS)-1:0]   grant_id,
  output logic [1:0]                          arb_perf_events
);

  localparam int         IDW   = $clog2(NUM_REQUESTERS);
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [NUM_REQUESTERS-1:0] occupied;
  logic [PKT_W-1:0]          buf_pkt [NUM_REQUESTERS];
  logic [IDW-1:0]            rr_ptr;
  logic [7:0]                starve_cnt;

  logic                      any_occ;
  logic                      restart_win;
  logic                      core_win;
  logic                      found;
  logic [IDW-1:0]            pick;
  logic [IDW-1:0]            idx;

  // Round-robin scan starting at rr_ptr; the index wraps naturally because
  // NUM_REQUESTERS is a power of two.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      idx = rr_ptr + IDW'(i);
      if (!found && occupied[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign any_occ     = |occupied;
  // A restart loses only when cores are waiting and have already been
  // passed over STARVE_LIMIT times in a row.
  assign restart_win = !stall && restart_valid && (!any_occ || (starve_cnt < LIMIT));
  assign core_win    = !stall && !restart_win && found;
  assign restart_ack = restart_win;
  assign req_ready   = ~occupied;

  // Holding-buffer occupancy. Accept needs an empty buffer and dequeue needs
  // a full one, so the two never collide on the same port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupied <= '0;
    end else begin
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
        if (req_valid[i] && !occupied[i]) begin
          occupied[i] <= 1'b1;
        end else if (core_win && (pick == IDW'(i))) begin
          occupied[i] <= 1'b0;
        end
      end
    end
  end

  // Buffer payload only matters while occupied, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (req_valid[i] && !occupied[i]) begin
        buf_pkt[i] <= req_packet[i*PKT_W +: PKT_W];
      end
    end
  end

  // Output grant register; holds its contents while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_valid      <= 1'b0;
      grant_packet     <= '0;
      grant_is_restart <= 1'b0;
      grant_id         <= '0;
    end else if (!stall) begin
      if (restart_win) begin
        grant_valid      <= 1'b1;
        grant_packet     <= restart_packet;
        grant_is_restart <= 1'b1;
        grant_id         <= '0;
      end else if (core_win) begin
        grant_valid      <= 1'b1;
        grant_packet     <= buf_pkt[pick];
        grant_is_restart <= 1'b0;
        grant_id         <= pick;
      end else begin
        grant_valid      <= 1'b0;
        grant_is_restart <= 1'b0;
      end
    end
  end

  // Fairness state: round-robin pointer and consecutive-restart counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else if (restart_win) begin
      if (!any_occ) begin
        starve_cnt <= '0;
      end else if (starve_cnt < LIMIT) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
    end else if (core_win) begin
      rr_ptr     <= pick + IDW'(1);
      starve_cnt <= '0;
    end
  end

`ifdef L2_ARB_PERF_EN
  logic [1:0] perf_q;

  // Pulses line up with the grant they describe. A core winning while a
  // restart is pending can only happen once the counter has saturated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= 2'b00;
    end else begin
      perf_q <= {core_win && restart_valid && (starve_cnt == LIMIT),
                 restart_win && any_occ};
    end
  end

  assign arb_perf_events = perf_q;
`else
  assign arb_perf_events = 2'b00;
`endif

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Testbench for l2_request_arbiter: directed scenarios from the feature list
// plus a randomized run, all checked against a behavioural model that tracks
// buffer contents, the round-robin position and the restart streak as plain
// integers.

module tb_l2_request_arbiter;

  localparam int N   = 4;
  localparam int LIM = 8;
  localparam int W   = 32;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_packet;
  logic [N-1:0]   req_ready;
  logic           restart_valid;
  logic [W-1:0]   restart_packet;
  logic           restart_ack;
  logic           stall;
  logic           grant_valid;
  logic [W-1:0]   grant_packet;
  logic           grant_is_restart;
  logic [1:0]     grant_id;
  logic [1:0]     arb_perf_events;

  always #5 clk = ~clk;

  l2_request_arbiter #(
    .NUM_REQUESTERS (N),
    .STARVE_LIMIT   (LIM),
    .PKT_W          (W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_packet       (req_packet),
    .req_ready        (req_ready),
    .restart_valid    (restart_valid),
    .restart_packet   (restart_packet),
    .restart_ack      (restart_ack),
    .stall            (stall),
    .grant_valid      (grant_valid),
    .grant_packet     (grant_packet),
    .grant_is_restart (grant_is_restart),
    .grant_id         (grant_id),
    .arb_perf_events  (arb_perf_events)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  bit           m_occ [N];
  logic [W-1:0] m_pkt [N];
  int           m_ptr;
  int           m_starve;
  logic         m_gv;
  logic         m_gr;
  logic [1:0]   m_gid;
  logic [W-1:0] m_gpkt;
  logic [1:0]   m_perf;
  logic         exp_ack;
  logic         obs_ack;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_occ[i] = 1'b0;
    m_ptr    = 0;
    m_starve = 0;
    m_gv     = 1'b0;
    m_gr     = 1'b0;
    m_gid    = 2'd0;
    m_gpkt   = '0;
    m_perf   = 2'b00;
    exp_ack  = 1'b0;
  endtask

  // Applies the arbitration rules for one rising edge using the inputs
  // currently driven.
  task automatic model_step();
    int     n_occ;
    int     j;
    bit     rwin;
    bit [N-1:0] acc;
    n_occ = 0;
    for (int i = 0; i < N; i++) if (m_occ[i]) n_occ++;
    for (int i = 0; i < N; i++) acc[i] = req_valid[i] && !m_occ[i];
    rwin   = 1'b0;
    m_perf = 2'b00;
    if (!stall) begin
      rwin = restart_valid && (n_occ == 0 || m_starve < LIM);
      if (rwin) begin
        m_gv   = 1'b1;
        m_gr   = 1'b1;
        m_gid  = 2'd0;
        m_gpkt = restart_packet;
        if (n_occ > 0) begin
          m_perf[0] = 1'b1;
          m_starve  = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
        end else begin
          m_starve = 0;
        end
      end else if (n_occ > 0) begin
        j = -1;
        for (int k = 0; k < N; k++)
          if (j < 0 && m_occ[(m_ptr + k) % N]) j = (m_ptr + k) % N;
        m_gv     = 1'b1;
        m_gr     = 1'b0;
        m_gid    = 2'(j);
        m_gpkt   = m_pkt[j];
        m_occ[j] = 1'b0;
        m_ptr    = (j + 1) % N;
        if (restart_valid) m_perf[1] = 1'b1;
        m_starve = 0;
      end else begin
        m_gv = 1'b0;
        m_gr = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        m_occ[i] = 1'b1;
        m_pkt[i] = req_packet[i*W +: W];
      end
    end
    exp_ack = rwin;
`ifndef L2_ARB_PERF_EN
    m_perf = 2'b00;
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    req_valid      = '0;
    req_packet     = '0;
    restart_valid  = 1'b0;
    restart_packet = '0;
    stall          = 1'b0;
  endtask

  // Settle, sample restart_ack mid-cycle, advance model, cross one edge.
  task automatic step_clk();
    #1;
    obs_ack = restart_ack;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = !m_occ[i];
    return r;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b1111) begin errors++; $display("FAIL reset_ready got %b want 1111", req_ready); end
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_gv got %b want 0", grant_valid); end
    checks++; if (grant_is_restart !== 1'b0) begin errors++; $display("FAIL reset_gr got %b want 0", grant_is_restart); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid got %0d want 0", grant_id); end
    checks++; if (grant_packet !== '0) begin errors++; $display("FAIL reset_pkt got %h want 0", grant_packet); end
    checks++; if (arb_perf_events !== 2'b00) begin errors++; $display("FAIL reset_perf got %b want 00", arb_perf_events); end
    checks++; if (restart_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", restart_ack); end
  endtask

  task automatic test_single();
    req_valid               = 4'b0100;
    req_packet[2*W +: W]    = 32'h0000_1000;
    step_clk();   // accept edge
    req_valid = '0;
    checks++; if (req_ready !== 4'b1011) begin errors++; $display("FAIL single_ready_low got %b want 1011", req_ready); end
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL single_early_gv got %b want 0", grant_valid); end
    step_clk();   // grant edge
    checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd2 || grant_is_restart !== 1'b0)
      begin errors++; $display("FAIL single_grant got v=%b id=%0d r=%b want v=1 id=2 r=0", grant_valid, grant_id, grant_is_restart); end
    checks++; if (grant_packet !== 32'h0000_1000) begin errors++; $display("FAIL single_pkt got %h want 00001000", grant_packet); end
    checks++; if (req_ready !== 4'b1111) begin errors++; $display("FAIL single_ready_back got %b want 1111", req_ready); end
    step_clk();
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", grant_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0] ids [5];
    logic [W-1:0] exp_pkt;
    ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    apply_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      req_packet[i*W +: W] = 32'hA0 + 32'(i);
      exp_q.push_back(32'hA0 + 32'(i));
    end
    exp_q.push_back(32'hB0);
    step_clk();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        req_valid[0]       = 1'b1;
        req_packet[0 +: W] = 32'hB0;
      end
      step_clk();
      req_valid = '0;
      exp_pkt = exp_q.pop_front();
      checks++; if (grant_valid !== 1'b1 || grant_id !== ids[k] || grant_packet !== exp_pkt)
        begin errors++; $display("FAIL rr_order step %0d got v=%b id=%0d pkt=%h want v=1 id=%0d pkt=%h", k, grant_valid, grant_id, grant_packet, ids[k], exp_pkt); end
    end
    step_clk();
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b want 0", grant_valid); end
  endtask

  task automatic test_starvation();
    int acks;
    bit got_core;
    apply_reset();
    req_valid            = 4'b0010;
    req_packet[1*W +: W] = 32'h1111;
    step_clk();
    req_valid      = '0;
    restart_valid  = 1'b1;
    restart_packet = 32'h5000;
    acks     = 0;
    got_core = 1'b0;
    for (int c = 0; c < 20 && !got_core; c++) begin
      step_clk();
      if (obs_ack) begin
        acks++;
        restart_packet = restart_packet + 32'd1;
      end
      if (grant_valid && !grant_is_restart) begin
        got_core = 1'b1;
        checks++; if (grant_id !== 2'd1 || grant_packet !== 32'h1111)
          begin errors++; $display("FAIL starve_core got id=%0d pkt=%h want id=1 pkt=00001111", grant_id, grant_packet); end
        checks++; if (acks != LIM) begin errors++; $display("FAIL starve_ack_count got %0d want %0d", acks, LIM); end
`ifdef L2_ARB_PERF_EN
        checks++; if (arb_perf_events !== 2'b10) begin errors++; $display("FAIL starve_perf got %b want 10", arb_perf_events); end
`else
        checks++; if (arb_perf_events !== 2'b00) begin errors++; $display("FAIL starve_perf got %b want 00", arb_perf_events); end
`endif
      end
    end
    if (!got_core) begin
      checks++; errors++;
      $display("FAIL starve_timeout got no core grant within 20 cycles, want one after %0d restarts", LIM);
    end
    step_clk();
    checks++; if (obs_ack !== 1'b1 || grant_is_restart !== 1'b1 || grant_valid !== 1'b1)
      begin errors++; $display("FAIL starve_resume got ack=%b r=%b v=%b want 1 1 1", obs_ack, grant_is_restart, grant_valid); end
    restart_valid = 1'b0;
    step_clk();
  endtask

  task automatic test_stall();
    logic [1:0] ids [3];
    ids = '{2'd1, 2'd2, 2'd3};
    apply_reset();
    req_valid = 4'b0111;
    for (int i = 0; i < N; i++) req_packet[i*W +: W] = 32'h2000 + 32'(i);
    step_clk();
    req_valid = '0;
    step_clk();
    checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd0)
      begin errors++; $display("FAIL stall_pre got v=%b id=%0d want v=1 id=0", grant_valid, grant_id); end
    stall          = 1'b1;
    restart_valid  = 1'b1;
    restart_packet = 32'h7777;
    req_valid      = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      step_clk();
      req_valid = '0;
      checks++; if (obs_ack !== 1'b0) begin errors++; $display("FAIL stall_ack cycle %0d got %b want 0", c, obs_ack); end
      checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd0 || grant_packet !== 32'h2000)
        begin errors++; $display("FAIL stall_hold cycle %0d got v=%b id=%0d pkt=%h want v=1 id=0 pkt=00002000", c, grant_valid, grant_id, grant_packet); end
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL stall_ready cycle %0d got %b want 0001", c, req_ready); end
    end
    stall = 1'b0;
    step_clk();
    checks++; if (obs_ack !== 1'b1 || grant_is_restart !== 1'b1 || grant_packet !== 32'h7777)
      begin errors++; $display("FAIL stall_release got ack=%b r=%b pkt=%h want 1 1 00007777", obs_ack, grant_is_restart, grant_packet); end
    restart_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step_clk();
      checks++; if (grant_valid !== 1'b1 || grant_is_restart !== 1'b0 || grant_id !== ids[k])
        begin errors++; $display("FAIL stall_rr step %0d got v=%b r=%b id=%0d want v=1 r=0 id=%0d", k, grant_valid, grant_is_restart, grant_id, ids[k]); end
    end
    step_clk();
  endtask

  task automatic test_restart_only();
    apply_reset();
    restart_valid  = 1'b1;
    restart_packet = 32'hCAFE_0001;
    step_clk();
    restart_valid = 1'b0;
    checks++; if (obs_ack !== 1'b1) begin errors++; $display("FAIL ronly_ack got %b want 1", obs_ack); end
    checks++; if (grant_valid !== 1'b1 || grant_is_restart !== 1'b1 || grant_id !== 2'd0 || grant_packet !== 32'hCAFE_0001)
      begin errors++; $display("FAIL ronly_grant got v=%b r=%b id=%0d pkt=%h want 1 1 0 cafe0001", grant_valid, grant_is_restart, grant_id, grant_packet); end
    step_clk();
    checks++; if (grant_valid !== 1'b0 || obs_ack !== 1'b0)
      begin errors++; $display("FAIL ronly_idle got v=%b ack=%b want 0 0", grant_valid, obs_ack); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req_valid = 4'b0111;
    step_clk();
    req_valid = 4'b1000;
    step_clk();
    req_valid = '0;
    checks++; if (grant_valid !== 1'b1 || req_ready !== 4'b0001)
      begin errors++; $display("FAIL areset_pre got v=%b ready=%b want 1 0001", grant_valid, req_ready); end
    #3;
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b1111) begin errors++; $display("FAIL areset_ready got %b want 1111", req_ready); end
    checks++; if (grant_valid !== 1'b0 || grant_is_restart !== 1'b0 || grant_id !== 2'd0 || grant_packet !== '0)
      begin errors++; $display("FAIL areset_grant got v=%b r=%b id=%0d pkt=%h want all 0", grant_valid, grant_is_restart, grant_id, grant_packet); end
    checks++; if (arb_perf_events !== 2'b00 || restart_ack !== 1'b0)
      begin errors++; $display("FAIL areset_misc got perf=%b ack=%b want 00 0", arb_perf_events, restart_ack); end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step_clk();
      checks++; if (grant_valid !== 1'b0 || req_ready !== 4'b1111)
        begin errors++; $display("FAIL areset_stale cycle %0d got v=%b ready=%b want 0 1111", c, grant_valid, req_ready); end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) begin
        req_valid[i]         = ($urandom_range(0, 2) == 0);
        req_packet[i*W +: W] = $urandom;
      end
      if (!restart_valid) begin
        restart_valid  = ($urandom_range(0, 2) == 0);
        restart_packet = $urandom;
      end
      step_clk();
      checks++; if (obs_ack !== exp_ack) begin errors++; $display("FAIL rand_ack cycle %0d got %b want %b", c, obs_ack, exp_ack); end
      checks++; if (req_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready cycle %0d got %b want %b", c, req_ready, exp_ready()); end
      checks++; if (grant_valid !== m_gv) begin errors++; $display("FAIL rand_gv cycle %0d got %b want %b", c, grant_valid, m_gv); end
      checks++; if (arb_perf_events !== m_perf) begin errors++; $display("FAIL rand_perf cycle %0d got %b want %b", c, arb_perf_events, m_perf); end
      if (m_gv) begin
        checks++; if (grant_packet !== m_gpkt || grant_is_restart !== m_gr || grant_id !== m_gid)
          begin errors++; $display("FAIL rand_grant cycle %0d got pkt=%h r=%b id=%0d want pkt=%h r=%b id=%0d", c, grant_packet, grant_is_restart, grant_id, m_gpkt, m_gr, m_gid); end
      end
      if (obs_ack) restart_valid = 1'b0;
    end
    clear_inputs();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_starvation();
    test_stall();
    test_restart_only();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
